// File: rtl/uart_rx_framed.sv
// 8N1 UART receiver with mid-bit sampling, framing-error/break handling and a
// single-entry valid/ready holding register that reports overruns.
module uart_rx_framed #(
    parameter int CLKFREQ = 12000000,
    parameter int BAUD    = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV  = CLKFREQ / BAUD;
    localparam int HALF = (DIV - 1) / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            rx_meta_q, rx_s_q;
    logic            deliver;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CW'(HALF)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s_q;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // A transfer in the same cycle frees the slot, so the new byte may load.
        if (deliver) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = shift_q;
                m_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            m_data_q    <= 8'h00;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Self-checking bench for uart_rx_framed: frames are driven bit by bit and the
// expected bytes and event cycles come from frame start times plus fixed latency.
module tb_uart_rx_framed;

    localparam int CLKFREQ = 12000000;
    localparam int BAUD    = 115200;
    localparam int DIV     = CLKFREQ / BAUD;
    localparam int HALF    = (DIV - 1) / 2;
    // Cycles from driving the start edge to m_valid/pulse visibility:
    // 2 synchronizer flops, 1 IDLE detect edge, HALF + 9*DIV to the stop sample, 1 register edge.
    localparam int LAT     = 2 + 1 + HALF + 9 * DIV + 1;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         rise_cyc[$];
    logic [7:0] rise_dat[$];
    logic [7:0] xfer_dat[$];
    int         fe_cyc[$];
    int         ov_cyc[$];
    int         valid_hi;
    int         busy_hi;
    int         viol;
    logic       prev_v, prev_fe, prev_ov;

    uart_rx_framed #(.CLKFREQ(CLKFREQ), .BAUD(BAUD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge, away from the active edge.
    initial begin
        prev_v = 1'b0; prev_fe = 1'b0; prev_ov = 1'b0;
        valid_hi = 0; busy_hi = 0; viol = 0;
    end
    always @(negedge clk) begin
        if (m_valid === 1'b1 && prev_v !== 1'b1) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(m_data);
        end
        if (m_valid === 1'b1) valid_hi++;
        if (busy === 1'b1) busy_hi++;
        if (m_valid === 1'b1 && m_ready === 1'b1) xfer_dat.push_back(m_data);
        if (frame_err === 1'b1) fe_cyc.push_back(cyc);
        if (overrun === 1'b1) ov_cyc.push_back(cyc);
        if ((frame_err === 1'b1 && overrun === 1'b1) ||
            (frame_err === 1'b1 && prev_fe === 1'b1) ||
            (overrun === 1'b1 && prev_ov === 1'b1)) viol++;
        prev_v  = m_valid;
        prev_fe = frame_err;
        prev_ov = overrun;
    end

    task automatic clear_mon();
        rise_cyc.delete();
        rise_dat.delete();
        xfer_dat.delete();
        fe_cyc.delete();
        ov_cyc.delete();
        valid_hi = 0;
        busy_hi  = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; c returns the cycle index of the start edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, output int c);
        c  = cyc;
        rx = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(DIV);
        end
        rx = stop_v;
        wait_cycles(DIV);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx = 1'b1; m_ready = 1'b0;
        wait_cycles(3);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        wait_cycles(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        int c;
        m_ready = 1'b1;
        clear_mon();
        send_frame(8'hA5, 1'b1, c);
        wait_cycles(2 * DIV);
        checks++; if (rise_cyc.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", rise_cyc.size()); end
        else begin
            checks++; if (rise_dat[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", rise_dat[0]); end
            checks++; if (rise_cyc[0] !== c + LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", rise_cyc[0], c + LAT); end
        end
        checks++; if (valid_hi !== 1) begin errors++; $display("FAIL single_valid_width got %0d want 1", valid_hi); end
        checks++; if (fe_cyc.size() + ov_cyc.size() !== 0) begin errors++; $display("FAIL single_pulses got %0d want 0", fe_cyc.size() + ov_cyc.size()); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        wait_cycles(20);
        rx = 1'b1;
        wait_cycles(DIV);
        checks++; if (busy_hi == 0) begin errors++; $display("FAIL glitch_busy_seen got %0d want >0", busy_hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy=%b want 0", busy); end
        checks++; if (valid_hi + fe_cyc.size() + ov_cyc.size() !== 0) begin
            errors++; $display("FAIL glitch_outputs got %0d events want 0", valid_hi + fe_cyc.size() + ov_cyc.size());
        end
    endtask

    task automatic test_frame_err();
        int c;
        clear_mon();
        send_frame(8'h3C, 1'b0, c);
        wait_cycles(2000);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got %b want 1", busy); end
        rx = 1'b1;
        wait_cycles(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_exit got busy=%b want 0", busy); end
        checks++; if (fe_cyc.size() !== 1) begin errors++; $display("FAIL fe_count got %0d want 1", fe_cyc.size()); end
        else begin
            checks++; if (fe_cyc[0] !== c + LAT) begin errors++; $display("FAIL fe_cycle got %0d want %0d", fe_cyc[0], c + LAT); end
        end
        checks++; if (valid_hi + ov_cyc.size() !== 0) begin errors++; $display("FAIL fe_no_valid got %0d want 0", valid_hi + ov_cyc.size()); end
    endtask

    task automatic test_overrun();
        int c1, c2;
        m_ready = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1, c1);
        rx = 1'b1; wait_cycles(DIV);
        send_frame(8'h22, 1'b1, c2);
        rx = 1'b1; wait_cycles(2 * DIV);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", m_valid); end
        checks++; if (m_data !== 8'h11) begin errors++; $display("FAIL ovr_data got %h want 11", m_data); end
        checks++; if (ov_cyc.size() !== 1) begin errors++; $display("FAIL ovr_count got %0d want 1", ov_cyc.size()); end
        else begin
            checks++; if (ov_cyc[0] !== c2 + LAT) begin errors++; $display("FAIL ovr_cycle got %0d want %0d", ov_cyc[0], c2 + LAT); end
        end
        checks++; if (fe_cyc.size() !== 0) begin errors++; $display("FAIL ovr_fe got %0d want 0", fe_cyc.size()); end
        m_ready = 1'b1;
        wait_cycles(1);
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b want 0", m_valid); end
        checks++; if (xfer_dat.size() !== 1 || xfer_dat[0] !== 8'h11) begin
            errors++; $display("FAIL ovr_xfer got %0d transfers want one of 11", xfer_dat.size());
        end
    endtask

    task automatic run_sequence(input logic [7:0] bytes[$], input int gap_min, input int gap_max, input string name);
        int c;
        int exp_cyc[$];
        m_ready = 1'b1;
        clear_mon();
        foreach (bytes[i]) begin
            send_frame(bytes[i], 1'b1, c);
            exp_cyc.push_back(c + LAT);
            rx = 1'b1;
            wait_cycles($urandom_range(gap_max, gap_min));
        end
        wait_cycles(2 * DIV);
        checks++; if (xfer_dat.size() !== bytes.size()) begin
            errors++; $display("FAIL %s_count got %0d want %0d", name, xfer_dat.size(), bytes.size());
        end else begin
            foreach (bytes[i]) begin
                checks++; if (xfer_dat[i] !== bytes[i]) begin errors++; $display("FAIL %s_data[%0d] got %h want %h", name, i, xfer_dat[i], bytes[i]); end
                checks++; if (rise_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL %s_cycle[%0d] got %0d want %0d", name, i, rise_cyc[i], exp_cyc[i]); end
            end
        end
        checks++; if (fe_cyc.size() + ov_cyc.size() !== 0) begin errors++; $display("FAIL %s_pulses got %0d want 0", name, fe_cyc.size() + ov_cyc.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        q = '{8'h00, 8'hFF, 8'h55};
        run_sequence(q, DIV, DIV, "b2b");
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        run_sequence(q, DIV, 3 * DIV, "rand");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int c;
        b = 8'h0F;
        m_ready = 1'b1;
        clear_mon();
        rx = 1'b0; wait_cycles(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = b[i]; wait_cycles(DIV);
        end
        rx = b[4];
        wait_cycles(DIV / 2);
        rst_n = 1'b0;
        wait_cycles(3);
        checks++; if ({m_valid, frame_err, overrun, busy} !== 4'b0000 || m_data !== 8'h00) begin
            errors++; $display("FAIL midrst_outputs got v%b fe%b ov%b busy%b d%h want all 0", m_valid, frame_err, overrun, busy, m_data);
        end
        rst_n = 1'b1;
        rx = 1'b1;
        wait_cycles(3 * DIV);
        checks++; if (rise_cyc.size() + fe_cyc.size() + ov_cyc.size() !== 0) begin
            errors++; $display("FAIL midrst_events got %0d want 0", rise_cyc.size() + fe_cyc.size() + ov_cyc.size());
        end
        clear_mon();
        send_frame(8'h81, 1'b1, c);
        wait_cycles(2 * DIV);
        checks++; if (rise_dat.size() !== 1 || rise_dat[0] !== 8'h81) begin
            errors++; $display("FAIL midrst_next got %0d bytes want one of 81", rise_dat.size());
        end else begin
            checks++; if (rise_cyc[0] !== c + LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", rise_cyc[0], c + LAT); end
        end
    endtask

    task automatic test_pulse_rules();
        checks++; if (viol !== 0) begin errors++; $display("FAIL pulse_rules got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
